// File: rtl/spawn_pkg.sv
// Shared definitions for the spawn-time arbiter and game_runtime:
// default bus widths, FSM state encodings and channel codes.
package spawn_pkg;

    localparam int DEF_MAXIMUM_TIMES           = 30;
    localparam int DEF_MAXIMUM_ATTACK_OBJECT   = 20;
    localparam int DEF_MAXIMUM_PLATFORM_OBJECT = 20;
    localparam int DEF_ROM_ADDR_W              = 10;
    localparam int DEF_DELAY_W                 = 8;
    localparam int DEF_TIMEOUT_CYCLES          = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        CH_ATTACK   = 1'b0,
        CH_PLATFORM = 1'b1
    } spawn_ch_t;

endpackage

// File: rtl/spawn_time_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin grant. req[0] is the attack
// channel, req[1] the platform channel. The favour pointer only moves
// when both channels compete and the grant is actually taken.
module rr_arbiter2
    import spawn_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic [1:0] req,
    input  logic      advance,
    output logic      gnt_valid,
    output spawn_ch_t gnt_ch
);

    spawn_ch_t favour_q;

    // Grant selection: a lone requester wins outright, a tie goes to the favoured channel.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_ch = favour_q;
        end else if (req[1]) begin
            gnt_ch = CH_PLATFORM;
        end else begin
            gnt_ch = CH_ATTACK;
        end
    end

    // Pointer update: after serving a tie, favour the loser next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            favour_q <= CH_ATTACK;
        end else if (advance && (req == 2'b11)) begin
            favour_q <= (favour_q == CH_ATTACK) ? CH_PLATFORM : CH_ATTACK;
        end
    end

endmodule

// File: rtl/spawn_time_arbiter.sv
// spawn_time_arbiter: serves the attack and platform next-spawn-time
// handshakes through one shared spawn-delay ROM port.
// Optional macro SPAWN_ARB_TIMEOUT_EN adds a ROM watchdog and the sticky
// rom_timeout_err output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transaction; arbitrate pending channels, latch the grant
// ISSUE    | one-cycle rom_req with latched table select and address
// WAIT     | hold address, wait for rom_valid (or watchdog expiry)
// WRITE    | publish current_time + delay, one-cycle update pulse
module spawn_time_arbiter
    import spawn_pkg::*;
#(
    parameter int MAXIMUM_TIMES           = DEF_MAXIMUM_TIMES,
    parameter int MAXIMUM_ATTACK_OBJECT   = DEF_MAXIMUM_ATTACK_OBJECT,
    parameter int MAXIMUM_PLATFORM_OBJECT = DEF_MAXIMUM_PLATFORM_OBJECT,
    parameter int ROM_ADDR_W              = DEF_ROM_ADDR_W,
    parameter int DELAY_W                 = DEF_DELAY_W,
    parameter int TIMEOUT_CYCLES          = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MAXIMUM_TIMES-1:0]           current_time,
    input  logic                               sync_attack_time,
    input  logic                               sync_platform_time,
    input  logic [MAXIMUM_ATTACK_OBJECT-1:0]   attack_i,
    input  logic [MAXIMUM_PLATFORM_OBJECT-1:0] platform_i,
    output logic                               rom_req,
    output logic                               rom_sel,
    output logic [ROM_ADDR_W-1:0]              rom_addr,
    input  logic                               rom_valid,
    input  logic [DELAY_W-1:0]                 rom_delay,
    output logic [MAXIMUM_TIMES-1:0]           next_attack_time,
    output logic [MAXIMUM_TIMES-1:0]           next_platform_time,
    output logic                               update_attack_time,
    output logic                               update_platform_time,
`ifdef SPAWN_ARB_TIMEOUT_EN
    output logic                               rom_timeout_err,
`endif
    output logic                               busy
);

    arb_state_t                 state_q, state_d;
    spawn_ch_t                  ch_q;
    spawn_ch_t                  gnt_ch;
    logic                       gnt_valid;
    logic                       grant;
    logic [1:0]                 pending;
    logic                       served_a_q, served_p_q;
    logic [ROM_ADDR_W-1:0]      addr_q;
    logic [DELAY_W-1:0]         delay_q;
    logic [MAXIMUM_TIMES-1:0]   held_a_q, held_p_q;
    logic [MAXIMUM_TIMES-1:0]   sum;
    logic                       timeout;

    // Only the low ROM_ADDR_W index bits address the ROM.
    logic                       unused_idx_bits;
    assign unused_idx_bits = ^{attack_i, platform_i};

    // A channel stays blocked after its acknowledge until the runtime releases sync.
    assign pending = {!sync_platform_time && !served_p_q,
                      !sync_attack_time   && !served_a_q};
    assign grant   = (state_q == ST_IDLE) && gnt_valid;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (pending),
        .advance   (grant),
        .gnt_valid (gnt_valid),
        .gnt_ch    (gnt_ch)
    );

`ifdef SPAWN_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // Watchdog down-counter: loaded in ISSUE, terminal count ends the WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == ST_WAIT) && (wd_q != '0)) begin
            wd_q <= wd_q - WD_W'(1);
        end
    end

    assign timeout = (state_q == ST_WAIT) && !rom_valid && (wd_q == '0);

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_timeout_err <= 1'b0;
        end else if (timeout) begin
            rom_timeout_err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gnt_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (rom_valid || timeout) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath: grant latch, delay capture, held results, served flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q       <= CH_ATTACK;
            addr_q     <= '0;
            delay_q    <= '0;
            held_a_q   <= '0;
            held_p_q   <= '0;
            served_a_q <= 1'b0;
            served_p_q <= 1'b0;
        end else begin
            if (grant) begin
                ch_q   <= gnt_ch;
                addr_q <= (gnt_ch == CH_ATTACK) ? attack_i[ROM_ADDR_W-1:0]
                                                : platform_i[ROM_ADDR_W-1:0];
            end
            if (state_q == ST_WAIT) begin
                if (rom_valid) begin
                    delay_q <= rom_delay;
                end else if (timeout) begin
                    delay_q <= '0;
                end
            end
            if (state_q == ST_WRITE) begin
                if (ch_q == CH_ATTACK) begin
                    held_a_q <= sum;
                end else begin
                    held_p_q <= sum;
                end
            end
            if (sync_attack_time) begin
                served_a_q <= 1'b0;
            end else if (update_attack_time) begin
                served_a_q <= 1'b1;
            end
            if (sync_platform_time) begin
                served_p_q <= 1'b0;
            end else if (update_platform_time) begin
                served_p_q <= 1'b1;
            end
        end
    end

    // Outputs: the new time is presented combinationally during WRITE so it
    // coincides with the update pulse, then held from the register.
    always_comb begin
        sum                  = current_time + {{(MAXIMUM_TIMES-DELAY_W){1'b0}}, delay_q};
        rom_req              = (state_q == ST_ISSUE);
        rom_sel              = 1'b0;
        rom_addr             = '0;
        update_attack_time   = 1'b0;
        update_platform_time = 1'b0;
        next_attack_time     = held_a_q;
        next_platform_time   = held_p_q;
        busy                 = (state_q != ST_IDLE);
        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            rom_sel  = ch_q;
            rom_addr = addr_q;
        end
        if (state_q == ST_WRITE) begin
            if (ch_q == CH_ATTACK) begin
                update_attack_time = 1'b1;
                next_attack_time   = sum;
            end else begin
                update_platform_time = 1'b1;
                next_platform_time   = sum;
            end
        end
    end

endmodule

// File: tb/tb_spawn_time_arbiter.sv
// Bench for spawn_time_arbiter: transaction-level timing model (grant cycle
// N, rom_req at N+1, update at N+3+k) driving a bench-side ROM, plus
// directed scenarios with literal expectations and a randomized run.
module tb_spawn_time_arbiter;

    localparam int TW = 30;
    localparam int AW = 20;
    localparam int PW = 20;
    localparam int RW = 10;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [TW-1:0] current_time;
    logic          sync_attack_time, sync_platform_time;
    logic [AW-1:0] attack_i;
    logic [PW-1:0] platform_i;
    logic          rom_req, rom_sel, rom_valid;
    logic [RW-1:0] rom_addr;
    logic [DW-1:0] rom_delay;
    logic [TW-1:0] next_attack_time, next_platform_time;
    logic          update_attack_time, update_platform_time, busy;
`ifdef SPAWN_ARB_TIMEOUT_EN
    logic          rom_timeout_err;
`endif

    spawn_time_arbiter #(
        .MAXIMUM_TIMES(TW), .MAXIMUM_ATTACK_OBJECT(AW), .MAXIMUM_PLATFORM_OBJECT(PW),
        .ROM_ADDR_W(RW), .DELAY_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .current_time(current_time),
        .sync_attack_time(sync_attack_time), .sync_platform_time(sync_platform_time),
        .attack_i(attack_i), .platform_i(platform_i),
        .rom_req(rom_req), .rom_sel(rom_sel), .rom_addr(rom_addr),
        .rom_valid(rom_valid), .rom_delay(rom_delay),
        .next_attack_time(next_attack_time), .next_platform_time(next_platform_time),
        .update_attack_time(update_attack_time), .update_platform_time(update_platform_time),
`ifdef SPAWN_ARB_TIMEOUT_EN
        .rom_timeout_err(rom_timeout_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit            m_active, m_served_a, m_served_p, m_favour_p, m_err;
    int            m_ch, m_k, cyc, g_cyc, last_grant, last_upd;
    logic [RW-1:0] m_addr;
    logic [DW-1:0] m_delay;
    logic [TW-1:0] m_held_a, m_held_p;
    int            log_q[$];
    bit            use_dir;
    int            dir_k;
    logic [DW-1:0] dir_da, dir_dp;
    int            req_seen, upd_seen;
    logic [RW-1:0] seen_addr;
    logic          seen_sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_active = 0; m_served_a = 0; m_served_p = 0; m_favour_p = 0; m_err = 0;
        m_held_a = '0; m_held_p = '0;
    endtask

    task automatic step(input bit rst, input bit sa, input bit sp,
                        input logic [AW-1:0] ai, input logic [PW-1:0] pi,
                        input logic [TW-1:0] ct, input bit noise);
        int            ph, upd_ph;
        bit            idle, in_win, upd, tmo, e_ua, e_up, pa, pp;
        logic [DW-1:0] d_eff;
        logic [TW-1:0] e_a, e_p;
        @(posedge clk);
        #1;
        idle   = !m_active;
        ph     = cyc - g_cyc;
        upd_ph = 3 + m_k;
        d_eff  = m_delay;
        tmo    = 0;
`ifdef SPAWN_ARB_TIMEOUT_EN
        if (m_active && m_k >= TO) begin
            upd_ph = 2 + TO;
            d_eff  = '0;
            tmo    = 1;
        end
`endif
        in_win = m_active && ph >= 2 && ph < upd_ph;
        reset              = rst;
        sync_attack_time   = sa;
        sync_platform_time = sp;
        attack_i           = ai;
        platform_i         = pi;
        current_time       = ct;
        rom_delay          = DW'($urandom);
        if (in_win && ph == 2 + m_k) begin
            rom_valid = 1'b1;
            rom_delay = m_delay;
        end else if (!in_win && noise) begin
            rom_valid = 1'b1;
        end else begin
            rom_valid = 1'b0;
        end
        upd  = m_active && ph == upd_ph;
        e_ua = upd && m_ch == 0;
        e_up = upd && m_ch == 1;
        e_a  = e_ua ? ct + TW'(d_eff) : m_held_a;
        e_p  = e_up ? ct + TW'(d_eff) : m_held_p;
        @(negedge clk);
        chk("busy", busy, m_active && ph >= 1);
        chk("rom_req", rom_req, m_active && ph == 1);
        chk("update_attack", update_attack_time, e_ua);
        chk("update_platform", update_platform_time, e_up);
        chk("next_attack", next_attack_time, e_a);
        chk("next_platform", next_platform_time, e_p);
        if (m_active && ph >= 1 && ph < upd_ph) begin
            chk("rom_sel", rom_sel, m_ch);
            chk("rom_addr", rom_addr, m_addr);
        end
`ifdef SPAWN_ARB_TIMEOUT_EN
        chk("timeout_err", rom_timeout_err, m_err || (upd && tmo));
`endif
        if (rom_req === 1'b1) begin
            req_seen++;
            seen_addr = rom_addr;
            seen_sel  = rom_sel;
        end
        if (update_attack_time === 1'b1 || update_platform_time === 1'b1) upd_seen++;
        if (rst) begin
            m_reset();
        end else begin
            pa = !sa && !m_served_a;
            pp = !sp && !m_served_p;
            if (upd) begin
                if (m_ch == 0) m_held_a = e_a; else m_held_p = e_p;
                m_active = 0;
                log_q.push_back(m_ch);
                last_upd = cyc;
                if (tmo) m_err = 1;
            end
            if (idle && (pa || pp)) begin
                if (pa && pp) begin
                    m_ch      = m_favour_p;
                    m_favour_p = !m_favour_p;
                end else begin
                    m_ch = pa ? 0 : 1;
                end
                m_addr     = (m_ch == 0) ? ai[RW-1:0] : pi[RW-1:0];
                m_k        = use_dir ? dir_k : int'($urandom_range(0, 3));
                m_delay    = use_dir ? ((m_ch == 0) ? dir_da : dir_dp) : DW'($urandom);
                m_active   = 1;
                g_cyc      = cyc;
                last_grant = cyc;
            end
            m_served_a = sa ? 1'b0 : (e_ua ? 1'b1 : m_served_a);
            m_served_p = sp ? 1'b0 : (e_up ? 1'b1 : m_served_p);
        end
        cyc++;
    endtask

    initial begin
        int r0, u0;
        logic [TW-1:0] ct;
        bit rr, ra, rp;
        reset = 1'b1; sync_attack_time = 1'b1; sync_platform_time = 1'b1;
        attack_i = '0; platform_i = '0; current_time = '0;
        rom_valid = 1'b0; rom_delay = '0;
        m_reset();
        cyc = 0; g_cyc = 0; m_k = 0; m_ch = 0; m_addr = '0; m_delay = '0;
        req_seen = 0; upd_seen = 0; seen_addr = '0; seen_sel = 1'b0;
        last_grant = 0; last_upd = 0;
        repeat (2) @(posedge clk);

        // reset state
        step(0, 1, 1, 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_next_attack", next_attack_time, 0);
        chk("reset_rom_req", rom_req, 0);

        // simultaneous requests after reset
        use_dir = 1; dir_k = 0; dir_da = 8'd7; dir_dp = 8'd9;
        log_q.delete();
        repeat (8) step(0, 0, 0, 3, 4, 1000, 0);
        step(0, 1, 1, 3, 4, 1000, 0);
        chk("pair1_count", log_q.size(), 2);
        chk("pair1_first", log_q[0], 0);
        chk("pair1_second", log_q[1], 1);
        chk("pair1_attack_time", next_attack_time, 1007);
        chk("pair1_platform_time", next_platform_time, 1009);
        repeat (8) step(0, 0, 0, 3, 4, 2000, 0);
        step(0, 1, 1, 3, 4, 2000, 0);
        chk("pair2_count", log_q.size(), 4);
        chk("pair2_first", log_q[2], 1);
        chk("pair2_second", log_q[3], 0);
        chk("pair2_attack_time", next_attack_time, 2007);
        chk("pair2_platform_time", next_platform_time, 2009);

        // single attack request, zero-wait ROM, then held-low sync
        dir_da = 8'd20;
        r0 = req_seen;
        repeat (7) step(0, 0, 1, 5, 0, 100, 0);
        chk("single_latency", last_upd - last_grant, 3);
        chk("single_next_attack", next_attack_time, 120);
        chk("single_addr", seen_addr, 5);
        chk("single_sel", seen_sel, 0);
        chk("held_low_one_req", req_seen - r0, 1);
        step(0, 1, 1, 5, 0, 100, 0);
        repeat (4) step(0, 0, 1, 6, 0, 100, 0);
        chk("rerequest_req", req_seen - r0, 2);

        // wrap-around
        step(0, 1, 1, 0, 0, 0, 0);
        dir_da = 8'd10;
        ct = 30'h3FFF_FFFB;
        repeat (4) step(0, 0, 1, 9, 0, ct, 0);
        step(0, 1, 1, 9, 0, ct, 0);
        chk("wrap_next_attack", next_attack_time, 5);

        // reset mid-WAIT, then a late rom_valid
        dir_k = 6; dir_da = 8'd33;
        u0 = upd_seen;
        repeat (4) step(0, 0, 1, 11, 0, 300, 0);
        chk("midwait_busy", busy, 1);
        step(1, 0, 1, 11, 0, 300, 0);
        step(0, 1, 1, 11, 0, 300, 1);
        repeat (2) step(0, 1, 1, 11, 0, 300, 0);
        chk("midwait_no_update", upd_seen - u0, 0);
        chk("midwait_busy_after", busy, 0);
        chk("midwait_next_attack", next_attack_time, 0);
        chk("midwait_next_platform", next_platform_time, 0);

`ifdef SPAWN_ARB_TIMEOUT_EN
        // ROM never answers
        dir_k = 20;
        repeat (18) step(0, 0, 1, 2, 0, 500, 0);
        step(0, 1, 1, 2, 0, 500, 0);
        chk("timeout_err_set", rom_timeout_err, 1);
        chk("timeout_next_attack", next_attack_time, 500);
        repeat (3) step(0, 1, 1, 2, 0, 500, 0);
        chk("timeout_err_sticky", rom_timeout_err, 1);
`endif

        // randomized traffic
        use_dir = 0;
        ct = 30'd12345;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom % 300) == 0;
            ra = ($urandom % 3) == 0;
            rp = ($urandom % 3) == 0;
            if (($urandom % 50) == 0) ct = TW'($urandom);
            else ct = ct + TW'($urandom_range(0, 3));
            step(rr, ra, rp, AW'($urandom), PW'($urandom), ct, ($urandom % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
